display_burst_responder: RTL

- Memory-side responder for the display file fetch bus; serves 4-word wrapping burst reads from two display file channels (plane A = ch0, plane B = ch1).
- Arbitrates the two channels round-robin and issues one aligned 8-byte block read to the memory controller.
- Returns the block critical-word-first, wrapping within the block, with per-beat valid strobes and a completion ack on the final beat.

---
 rtl/display_burst_responder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/display_burst_responder.sv
// rtl/display_burst_responder.sv - two-channel display fetch responder, critical-word-first 4-beat bursts
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   address0/as0               ch0 (plane A) byte address and request strobe
//   bus_ack0/burstdata_valid0  ch0 burst-complete pulse and beat valid
//   address1/as1               ch1 (plane B) byte address and request strobe
//   bus_ack1/burstdata_valid1  ch1 burst-complete pulse and beat valid
//   dout                       shared beat data, qualified by the per-channel valid
//   mem_req/mem_addr/mem_gnt   block read request handshake, 8-byte block address
//   mem_rdata/mem_rvalid       block read data, words 0..3 in linear order
module display_burst_responder #(
    parameter int ADDR_W = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address0,
    input  logic              as0,
    output logic              bus_ack0,
    output logic              burstdata_valid0,
    input  logic [ADDR_W-1:0] address1,
    input  logic              as1,
    output logic              bus_ack1,
    output logic              burstdata_valid1,
    output logic [15:0]       dout,
    output logic              mem_req,
    output logic [ADDR_W-4:0] mem_addr,
    input  logic              mem_gnt,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_rvalid
);

    typedef enum logic [1:0] {IDLE, REQ, STREAM, DRAIN} state_t;

    state_t      state;
    logic        chan;          // granted channel
    logic        last_served;
    logic [1:0]  s;             // critical (start) word
    logic [1:0]  k;             // incoming beat index
    logic [1:0]  d;             // drain index
    logic [15:0] buffer [0:2];  // words ahead of the critical word, replayed after word 3

    // The requester's strobe is still high during its ack cycle, so a channel
    // whose ack is on the outputs right now must not be granted again.
    logic elig0, elig1, grant1, any_grant;
    logic [ADDR_W-4:0] sel_blk;
    logic [1:0]        sel_s;
    logic              unused_addr_bits;

    assign elig0     = as0 & ~bus_ack0;
    assign elig1     = as1 & ~bus_ack1;
    assign grant1    = elig1 & (~elig0 | ~last_served);
    assign any_grant = elig0 | elig1;
    assign sel_blk   = grant1 ? address1[ADDR_W-1:3] : address0[ADDR_W-1:3];
    assign sel_s     = grant1 ? address1[2:1] : address0[2:1];
    assign unused_addr_bits = ^{address0[0], address1[0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            chan             <= 1'b0;
            last_served      <= 1'b1;
            s                <= 2'd0;
            k                <= 2'd0;
            d                <= 2'd0;
            mem_req          <= 1'b0;
            mem_addr         <= '0;
            dout             <= 16'd0;
            bus_ack0         <= 1'b0;
            bus_ack1         <= 1'b0;
            burstdata_valid0 <= 1'b0;
            burstdata_valid1 <= 1'b0;
        end else begin
            burstdata_valid0 <= 1'b0;
            burstdata_valid1 <= 1'b0;
            bus_ack0         <= 1'b0;
            bus_ack1         <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_grant) begin
                        chan        <= grant1;
                        last_served <= grant1;
                        s           <= sel_s;
                        mem_addr    <= sel_blk;
                        mem_req     <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        k       <= 2'd0;
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    if (mem_rvalid) begin
                        if (k >= s) begin
                            dout             <= mem_rdata;
                            burstdata_valid0 <= ~chan;
                            burstdata_valid1 <= chan;
                            // With s=0 word 3 is the fourth and final beat.
                            bus_ack0         <= ~chan & (k == 2'd3) & (s == 2'd0);
                            bus_ack1         <= chan & (k == 2'd3) & (s == 2'd0);
                        end else begin
                            buffer[k] <= mem_rdata;
                        end
                        k <= k + 2'd1;
                        if (k == 2'd3) begin
                            d     <= 2'd0;
                            state <= (s == 2'd0) ? IDLE : DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    dout             <= buffer[d];
                    burstdata_valid0 <= ~chan;
                    burstdata_valid1 <= chan;
                    bus_ack0         <= ~chan & (d == s - 2'd1);
                    bus_ack1         <= chan & (d == s - 2'd1);
                    d                <= d + 2'd1;
                    if (d == s - 2'd1) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
